int2str_scheduler: RTL and testbench
====================================

Name: int2str_scheduler

Overview:
- Shares one serial binary-to-ASCII-decimal converter between pReq requesters.
- Arbitration is round-robin. The block latches the winner's binary value and runs a shift-add-3 (double-dabble) conversion, one bit per clock.
- The result is presented as a fixed-width ASCII string with a requester tag, under a valid/ready handshake.
- Sits between multiple status/telemetry sources and a single text sink (UART/LCD formatter).

Parameters:
- pBitWidth, 16, width of each binary operand.
- pDigits, 5, number of decimal digits produced. Elaboration error unless 10^pDigits > 2^pBitWidth-1.
- pReq, 4, number of requesters (>=2).

Ports:
- iClock  input  1  clock, rising edge.
- iReset  input  1  synchronous, active-high reset.
- iReq  input  pReq  per-requester level request; held until granted.
- iBinary  input  pReq*pBitWidth  operand of requester r at [r*pBitWidth +: pBitWidth].
- oGrant  output  pReq  one-hot, one-cycle pulse: operand of that requester latched this edge.
- oBusy  output  1  high in any state but IDLE.
- oValid  output  1  result available.
- iReady  input  1  sink accepts result when oValid&iReady.
- oString  output  8*pDigits  ASCII digits. Digit k (10^k) is at [8k+7:8k] = {4'h3, bcd_k}. Leading zeros are kept.
- oTag  output  $clog2(pReq)  index of the requester whose result is on oString.

Behaviour:
- All state updates on posedge iClock. iReset has priority over everything.
- Reset values:
  - state=IDLE, rr pointer=0.
  - oGrant=0, oBusy=0, oValid=0, oTag=0.
  - oString = all 8'h30 ("00000").
  - bit counter=0, BCD shift register=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If any iReq: oGrant is driven combinationally to the first set request searching from pointer, pointer+1, … (mod pReq).
  - At that edge: latch the winner's operand, clear BCD, counter=0, tag=winner, pointer=winner+1 mod pReq, go to SHIFT.
  - If no request: stay in IDLE.
- SHIFT, one cycle per operand bit:
  - Every BCD digit >=5 gets +3.
  - Then {BCD, operand} shifts left by 1, MSB of operand entering digit 0.
  - When counter==pBitWidth-1: copy the final BCD to the oString register and tag to oTag, then go to DONE. Otherwise counter+1.
- DONE:
  - oValid=1; oString and oTag are stable.
  - On iReady=1: go to IDLE. oValid drops next cycle.
  - A new grant is earliest in the IDLE cycle after that.
- Latency: grant at cycle T → oValid first high at T+pBitWidth+1 (17 at defaults). Max throughput is one result per pBitWidth+2 cycles.
- iReq is sampled only in IDLE. Requests raised, dropped or changed during SHIFT/DONE are ignored. iBinary of non-winners is don't-care.
- oString/oTag hold the last result outside DONE. They update only on the SHIFT→DONE edge.
- Simultaneous requests: at most one grant per IDLE cycle. The rr pointer guarantees every continuously asserted request is granted within pReq conversions.
- Operand extremes: 0 → all '0'. 2^pBitWidth-1 converts exactly; no overflow is possible given the pDigits check.
- Reset mid-SHIFT or mid-DONE: the conversion is aborted and all reset values apply next cycle. No grant and no valid are issued for the aborted job.
- iReady while not oValid: ignored.

Decomposition:
- Package int2str_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - ASCII_DIGIT_HI = 4'h3;
  - a digits_needed(bitwidth) constant function used for the pDigits check.
- Sub-module bcd_digit_cell:
  - Inputs: 4-bit digit, shift-in bit, shift enable, clear.
  - Outputs: registered digit and shift-out bit (MSB after add-3).
  - The scheduler instantiates pDigits of them in a chain.
- Round-robin select stays inline in int2str_scheduler.

Test Plan (pBitWidth=16, pDigits=5, pReq=4):
- Reset, then only iReq[0], operand 16'd12345 → oGrant=4'b0001 for 1 cycle; oValid 17 cycles later; oString=40'h3132333435; oTag=0; oBusy high throughout.
- Operand 16'd65535 → "65535" (40'h3635353335). Operand 0 → "00000" (40'h3030303030).
- iReq=4'b1111 held, iReady=1 → grants in order 0,1,2,3 with tags matching. Then iReq=4'b0101 → grants 0 then 2.
- Backpressure: iReady=0 for 10 cycles in DONE, iReq[1] raised → oValid, oString, oTag stable; no grant. iReady=1 → IDLE next cycle, grant 0010 the cycle after.
- iReset pulsed at SHIFT cycle 7 → next cycle oBusy=0, oValid=0, oString="00000", oTag=0; no oValid ever for that job. Next iReq[3] (pointer reset to 0) → grant 1000.
- Requester 2 granted, then iReq[2] dropped and iBinary[2] changed mid-SHIFT → result reflects the latched operand; no second grant for requester 2.

Source files
------------

// File: rtl/int2str_pkg.sv
// Shared constants for the int2str scheduler: state encoding, ASCII nibble,
// and the digit-count helper used to validate pDigits at elaboration.
package int2str_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Upper nibble of every ASCII decimal digit ('0' = 8'h30).
    localparam logic [3:0] ASCII_DIGIT_HI = 4'h3;

    // Number of decimal digits needed to print 2^bitwidth-1.
    function automatic int digits_needed(input int bitwidth);
        logic [63:0] v;
        int          n;
        v = (64'd1 << bitwidth) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the double-dabble chain: add-3 correction, then shift left
// by one with iBit entering at the LSB. oCarry feeds the next-higher digit.
module bcd_digit_cell
    import int2str_pkg::*;
(
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iClear,
    input  logic       iShift,
    input  logic       iBit,
    output logic [3:0] oShifted,
    output logic       oCarry
);

    logic [3:0] digit_q, digit_d;
    logic [3:0] adj;

    // Add-3 correction and the value this digit takes after the shift.
    always_comb begin
        adj      = (digit_q >= 4'd5) ? digit_q + 4'd3 : digit_q;
        oCarry   = adj[3];
        oShifted = {adj[2:0], iBit};
        digit_d  = digit_q;
        if (iClear) begin
            digit_d = 4'd0;
        end else if (iShift) begin
            digit_d = oShifted;
        end
    end

    // Digit register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/int2str_scheduler.sv
// Round-robin arbiter in front of one serial binary-to-ASCII converter.
// The winner's operand is latched, shifted one bit per clock through a chain
// of BCD cells, and the final digits are held as an ASCII string until the
// sink accepts them.
module int2str_scheduler
    import int2str_pkg::*;
#(
    parameter int pBitWidth = 16,
    parameter int pDigits   = 5,
    parameter int pReq      = 4
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic [pReq-1:0]           iReq,
    input  logic [pReq*pBitWidth-1:0] iBinary,
    output logic [pReq-1:0]           oGrant,
    output logic                      oBusy,
    output logic                      oValid,
    input  logic                      iReady,
    output logic [8*pDigits-1:0]      oString,
    output logic [$clog2(pReq)-1:0]   oTag
);

    localparam int PW = $clog2(pReq);
    localparam int CW = (pBitWidth > 1) ? $clog2(pBitWidth) : 1;

    if (pReq < 2) begin : g_req_chk
        $error("int2str_scheduler: pReq must be >= 2");
    end
    if (pDigits < digits_needed(pBitWidth)) begin : g_dig_chk
        $error("int2str_scheduler: pDigits too small for pBitWidth");
    end

    logic [1:0]             state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d, tag_q, tag_d, otag_q, otag_d, win;
    logic [pBitWidth-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [8*pDigits-1:0]   str_q, str_d;
    logic                   found, start, shift_en, last;
    logic [pDigits-1:0][3:0] dig_nxt;
    logic [pDigits-1:0]     carry, sin;

    // Round-robin pick: first set request at ptr, ptr+1, ... (mod pReq).
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < pReq; i++) begin
            idx = (int'(ptr_q) + i) % pReq;
            if (!found && iReq[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign start    = (state_q == S_IDLE) && found && !iReset;
    assign shift_en = (state_q == S_SHIFT);
    assign last     = shift_en && (cnt_q == CW'(pBitWidth - 1));

    // One-hot grant pulse during the IDLE cycle that latches the operand.
    always_comb begin
        oGrant = '0;
        if (start) begin
            oGrant[win] = 1'b1;
        end
    end

    // Operand MSB feeds digit 0; each digit's carry feeds the next one up.
    assign sin[0] = opnd_q[pBitWidth-1];
    for (genvar k = 0; k < pDigits; k++) begin : g_cell
        if (k > 0) begin : g_link
            assign sin[k] = carry[k-1];
        end
        bcd_digit_cell u_cell (
            .iClock   (iClock),
            .iReset   (iReset),
            .iClear   (start),
            .iShift   (shift_en),
            .iBit     (sin[k]),
            .oShifted (dig_nxt[k]),
            .oCarry   (carry[k])
        );
    end

    // FSM next state, operand/counter update and result capture.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tag_d   = tag_q;
        otag_d  = otag_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        str_d   = str_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opnd_d  = iBinary[int'(win)*pBitWidth +: pBitWidth];
                    cnt_d   = '0;
                    tag_d   = win;
                    ptr_d   = (int'(win) == pReq - 1) ? '0 : win + PW'(1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                opnd_d = opnd_q << 1;
                if (last) begin
                    for (int k = 0; k < pDigits; k++) begin
                        str_d[8*k +: 8] = {ASCII_DIGIT_HI, dig_nxt[k]};
                    end
                    otag_d  = tag_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (iReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any job in flight.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            tag_q   <= '0;
            otag_q  <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            str_q   <= {pDigits{8'h30}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tag_q   <= tag_d;
            otag_q  <= otag_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            str_q   <= str_d;
        end
    end

    assign oBusy   = (state_q != S_IDLE);
    assign oValid  = (state_q == S_DONE);
    assign oString = str_q;
    assign oTag    = otag_q;

endmodule

// File: tb/tb_int2str_scheduler.sv
// Directed bench for int2str_scheduler at 16-bit / 5-digit / 4-requester.
module tb_int2str_scheduler;

    localparam int W = 16;
    localparam int D = 5;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           ready;
    logic [R-1:0]   req;
    logic [R*W-1:0] bin;
    logic [R-1:0]   grant;
    logic           busy, valid;
    logic [8*D-1:0] str;
    logic [1:0]     tag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0]   op;
        int             r;
        logic [8*D-1:0] exp_str;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    int2str_scheduler #(.pBitWidth(W), .pDigits(D), .pReq(R)) dut (
        .iClock  (clk),
        .iReset  (rst),
        .iReq    (req),
        .iBinary (bin),
        .oGrant  (grant),
        .oBusy   (busy),
        .oValid  (valid),
        .iReady  (ready),
        .oString (str),
        .oTag    (tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant, check it, then consume the grant edge.
    task automatic wait_grant(input logic [R-1:0] exp, input string name);
        int n;
        n = 0;
        #1;
        while (grant == '0 && n < 60) begin
            step();
            n++;
        end
        chk(name, grant, exp);
        step();
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid && cyc < 60) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        int  n, cnt;
        logic ok;
        logic [8*D-1:0] s;
        logic [1:0]     t;

        vecs[0] = '{16'd12345, 0, 40'h3132333435};
        vecs[1] = '{16'd65535, 1, 40'h3635353335};
        vecs[2] = '{16'd0,     2, 40'h3030303030};
        vecs[3] = '{16'd1,     3, 40'h3030303031};
        vecs[4] = '{16'd10009, 0, 40'h3130303039};
        vecs[5] = '{16'd40000, 2, 40'h3430303030};
        vecs[6] = '{16'd99,    1, 40'h3030303939};

        rst = 1'b1; ready = 1'b0; req = '0; bin = '0;
        step(); step();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_str", str, 40'h3030303030);
        chk("rst_tag", tag, 0);
        rst = 1'b0;
        step();

        // Single-requester conversions with latency check.
        foreach (vecs[i]) begin
            bin = '0;
            bin[vecs[i].r*W +: W] = vecs[i].op;
            req = R'(1) << vecs[i].r;
            #1;
            chk($sformatf("v%0d_grant", i), grant, R'(1) << vecs[i].r);
            step();
            req = '0;
            n = 1; ok = 1'b1;
            while (!valid && n < 60) begin
                ok &= busy;
                step();
                n++;
            end
            chk($sformatf("v%0d_latency", i), n, 17);
            chk($sformatf("v%0d_busy", i), ok & busy, 1);
            chk($sformatf("v%0d_str", i), str, vecs[i].exp_str);
            chk($sformatf("v%0d_tag", i), tag, vecs[i].r);
            ready = 1'b1;
            step();
            chk($sformatf("v%0d_drop", i), valid, 0);
            ready = 1'b0;
        end

        // Round robin with all requests held, then 0101.
        rst = 1'b1; step(); rst = 1'b0;
        for (int r = 0; r < R; r++) bin[r*W +: W] = W'(100 + r);
        req = 4'b1111; ready = 1'b1;
        for (int g = 0; g < R; g++) begin
            wait_grant(R'(1) << g, $sformatf("rr_grant%0d", g));
            wait_valid(cnt);
            chk($sformatf("rr_tag%0d", g), tag, g);
            chk($sformatf("rr_str%0d", g), str, {24'h303031, 8'h30, 4'h3, 4'(g)});
        end
        req = 4'b0101;
        wait_grant(4'b0001, "rr5_grant0");
        wait_valid(cnt);
        wait_grant(4'b0100, "rr5_grant2");
        req = '0;
        wait_valid(cnt);
        chk("rr5_tag2", tag, 2);
        step();
        ready = 1'b0;

        // Backpressure: result held while iReady low, pending request waits.
        bin[0 +: W] = 16'd7;
        req = 4'b0001;
        wait_grant(4'b0001, "bp_grant0");
        req = '0;
        wait_valid(cnt);
        chk("bp_valid", valid, 1);
        chk("bp_str", str, 40'h3030303037);
        s = str; t = tag;
        req = 4'b0010;
        bin[W +: W] = 16'd321;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            ok &= valid && (str == s) && (tag == t) && (grant == '0);
        end
        chk("bp_hold", ok, 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("bp_idle_valid", valid, 0);
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_grant", grant, 4'b0010);
        step();
        req = '0;
        wait_valid(cnt);
        chk("bp_str1", str, 40'h3030333231);
        chk("bp_tag1", tag, 1);
        ready = 1'b1; step(); ready = 1'b0;

        // Reset in SHIFT cycle 7 aborts the job.
        bin[W +: W] = 16'd5555;
        req = 4'b0010;
        wait_grant(4'b0010, "ra_grant1");
        req = '0;
        for (int c = 0; c < 6; c++) step();
        chk("ra_busy_pre", busy, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("ra_busy", busy, 0);
        chk("ra_valid", valid, 0);
        chk("ra_str", str, 40'h3030303030);
        chk("ra_tag", tag, 0);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            ok |= valid | (grant != '0);
            step();
        end
        chk("ra_no_valid", ok, 0);
        bin[3*W +: W] = 16'd42;
        req = 4'b1000;
        wait_grant(4'b1000, "ra_grant3");
        req = '0;
        wait_valid(cnt);
        chk("ra_str3", str, 40'h3030303432);
        chk("ra_tag3", tag, 3);
        ready = 1'b1; step(); ready = 1'b0;

        // Operand and request changed mid-SHIFT do not affect the job.
        bin[2*W +: W] = 16'd4321;
        req = 4'b0100;
        wait_grant(4'b0100, "mc_grant2");
        step(); step(); step();
        req = '0;
        bin[2*W +: W] = 16'd9999;
        wait_valid(cnt);
        chk("mc_str", str, 40'h3034333231);
        chk("mc_tag", tag, 2);
        ready = 1'b1; step(); ready = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            ok |= (grant != '0) | valid;
            step();
        end
        chk("mc_no_regrant", ok, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
